// File: rtl/down_counter_src.sv
// Loadable down-counter feeding the zero-detect comparator.
// Every output is a flop, so the downstream detector sees a clean count.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | parked, count held, en/ack ignored until the next load
//   S_RUN  | counting down on each enabled edge
//   S_DONE | count at zero, done held until ack or load
module down_counter_src #(
  parameter int WIDTH       = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             ack,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_reload_val;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_reload_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = cnt;
    w_reload_nxt = r_reload_val;
    if (load) begin
      w_cnt_nxt    = load_val;
      w_reload_nxt = load_val;
      w_state_nxt  = (load_val != '0) ? S_RUN : S_DONE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_RUN: begin
          // RUN is never entered at zero, so the <=1 branch is the terminal count
          if (en) begin
            if (cnt > ONE) begin
              w_cnt_nxt = cnt - ONE;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_cnt_nxt = '0;
          if (ack) begin
            if (AUTO_RELOAD) begin
              w_cnt_nxt   = r_reload_val;
              w_state_nxt = (r_reload_val != '0) ? S_RUN : S_DONE;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      cnt          <= '0;
      r_reload_val <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      cnt          <= w_cnt_nxt;
      r_reload_val <= w_reload_nxt;
      busy         <= (w_state_nxt == S_RUN);
      done         <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_down_counter_src.sv
// Bench for down_counter_src: vector table plus hand sequences, checked
// through an expectation queue against plain and auto-reload instances.
module tb_down_counter_src;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        ack;
  logic [15:0] cnt0, cnt1;
  logic        busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        r;
    logic        ld;
    logic [15:0] lv;
    logic        e;
    logic        a;
    logic [15:0] ec;
    logic        eb;
    logic        ed;
    string       nm;
  } vec_t;

  typedef struct {
    logic [15:0] ec;
    logic        eb;
    logic        ed;
    string       nm;
    bit          which;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];

  down_counter_src #(.WIDTH(16), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .ack(ack),
    .cnt(cnt0), .busy(busy0), .done(done0)
  );

  down_counter_src #(.WIDTH(16), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .ack(ack),
    .cnt(cnt1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addv(input logic r, input logic ld, input logic [15:0] lv,
                      input logic e, input logic a, input logic [15:0] ec,
                      input logic eb, input logic ed, input string nm);
    vec_t v;
    v = '{r, ld, lv, e, a, ec, eb, ed, nm};
    vt.push_back(v);
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] lv,
                      input logic e, input logic a, input logic [15:0] ec,
                      input logic eb, input logic ed, input string nm, input bit which);
    exp_t x;
    logic [15:0] gc;
    logic        gb, gd;
    rst = r; load = ld; load_val = lv; en = e; ack = a;
    exp_q.push_back('{ec, eb, ed, nm, which});
    @(posedge clk);
    #1;
    x  = exp_q.pop_front();
    gc = x.which ? cnt1  : cnt0;
    gb = x.which ? busy1 : busy0;
    gd = x.which ? done1 : done0;
    n_cmp++;
    if (gc !== x.ec || gb !== x.eb || gd !== x.ed) begin
      n_err++;
      $display("FAIL %s: got cnt=%h busy=%b done=%b, need cnt=%h busy=%b done=%b",
               x.nm, gc, gb, gd, x.ec, x.eb, x.ed);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    logic [15:0] ec;
    logic        e;
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //   rst ld lv     en ack  cnt     busy done
    addv(1, 0, 16'd0, 0, 0, 16'd0, 0, 0, "reset");
    addv(0, 0, 16'd0, 1, 1, 16'd0, 0, 0, "idle_after_reset");
    addv(0, 1, 16'd5, 1, 0, 16'd5, 1, 0, "load5");
    addv(0, 0, 16'd0, 1, 0, 16'd4, 1, 0, "dec4");
    addv(0, 0, 16'd0, 1, 0, 16'd3, 1, 0, "dec3");
    addv(0, 0, 16'd0, 1, 0, 16'd2, 1, 0, "dec2");
    addv(0, 0, 16'd0, 1, 0, 16'd1, 1, 0, "dec1");
    addv(0, 0, 16'd0, 1, 0, 16'd0, 0, 1, "terminal");
    addv(0, 0, 16'd0, 1, 0, 16'd0, 0, 1, "done_hold_en");
    addv(0, 0, 16'd0, 0, 1, 16'd0, 0, 0, "ack_to_idle");
    addv(0, 0, 16'd0, 1, 0, 16'd0, 0, 0, "idle_ignore_en");
    addv(0, 1, 16'd0, 1, 0, 16'd0, 0, 1, "load0_done");
    addv(0, 0, 16'd0, 0, 0, 16'd0, 0, 1, "load0_hold");
    addv(0, 0, 16'd0, 0, 1, 16'd0, 0, 0, "load0_ack");
    addv(0, 1, 16'd3, 1, 0, 16'd3, 1, 0, "load3");
    addv(0, 0, 16'd0, 1, 0, 16'd2, 1, 0, "load3_dec");
    addv(0, 1, 16'd7, 1, 0, 16'd7, 1, 0, "load_beats_en");
    addv(0, 0, 16'd0, 0, 0, 16'd7, 1, 0, "run_hold");
    addv(0, 0, 16'd0, 0, 1, 16'd7, 1, 0, "run_ignore_ack");
    addv(0, 0, 16'd0, 1, 0, 16'd6, 1, 0, "dec6");
    addv(0, 1, 16'd9, 0, 0, 16'd9, 1, 0, "load9");
    addv(1, 0, 16'd0, 1, 0, 16'd0, 0, 0, "rst_mid_run");
    addv(0, 0, 16'd0, 1, 0, 16'd0, 0, 0, "post_rst_en1");
    addv(0, 0, 16'd0, 1, 1, 16'd0, 0, 0, "post_rst_en2");
    addv(0, 1, 16'd1, 0, 0, 16'd1, 1, 0, "load1");
    addv(0, 0, 16'd0, 1, 0, 16'd0, 0, 1, "load1_terminal");
    addv(0, 1, 16'd4, 1, 1, 16'd4, 1, 0, "load_beats_ack");
    addv(0, 1, 16'd2, 0, 0, 16'd2, 1, 0, "b2b_load_a");
    addv(0, 1, 16'd6, 0, 0, 16'd6, 1, 0, "b2b_load_b");
    addv(1, 1, 16'd8, 1, 1, 16'd0, 0, 0, "rst_beats_load");

    for (int i = 0; i < vt.size(); i++)
      step(vt[i].r, vt[i].ld, vt[i].lv, vt[i].e, vt[i].a,
           vt[i].ec, vt[i].eb, vt[i].ed, vt[i].nm, 1'b0);

    // Max load with en toggling: decrements only on enabled edges.
    step(0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 1, 0, "load_ffff", 1'b0);
    ec = 16'hFFFF;
    for (int i = 0; i < 600; i++) begin
      e = (i % 2 == 0);
      if (e) ec = ec - 16'd1;
      step(0, 0, 16'd0, e, 0, ec, 1, 0, "toggle_ffff", 1'b0);
    end

    // Small load with toggling to reach terminal count after N enabled edges.
    step(0, 1, 16'd4, 0, 0, 16'd4, 1, 0, "load4_tog", 1'b0);
    ec = 16'd4;
    for (int i = 0; i < 10; i++) begin
      e = (i % 2 == 1);
      if (e && ec != 16'd0) ec = ec - 16'd1;
      step(0, 0, 16'd0, e, 0, ec, (ec != 16'd0), (ec == 16'd0), "toggle4", 1'b0);
    end

    // Auto-reload instance.
    step(1, 0, 16'd0, 0, 0, 16'd0, 0, 0, "ar_reset",     1'b1);
    step(0, 1, 16'd2, 1, 0, 16'd2, 1, 0, "ar_load2",     1'b1);
    step(0, 0, 16'd0, 1, 0, 16'd1, 1, 0, "ar_dec1",      1'b1);
    step(0, 0, 16'd0, 1, 0, 16'd0, 0, 1, "ar_terminal",  1'b1);
    step(0, 0, 16'd0, 0, 0, 16'd0, 0, 1, "ar_done_hold", 1'b1);
    step(0, 0, 16'd0, 0, 1, 16'd2, 1, 0, "ar_reload",    1'b1);
    step(0, 0, 16'd0, 1, 0, 16'd1, 1, 0, "ar_dec1b",     1'b1);
    step(0, 0, 16'd0, 1, 0, 16'd0, 0, 1, "ar_terminal2", 1'b1);
    step(0, 1, 16'd0, 0, 0, 16'd0, 0, 1, "ar_load0",     1'b1);
    step(0, 0, 16'd0, 0, 1, 16'd0, 0, 1, "ar_ack_zero",  1'b1);
    step(0, 1, 16'd3, 0, 1, 16'd3, 1, 0, "ar_load_ack",  1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
